// File: rtl/pkg_msg.sv
// Shared message-protocol definitions: command codes, frame header byte,
// CRC8 polynomial and helper functions, plus the response framer state type.
package pkg_msg;

    localparam logic [7:0] BYTE_HEADER      = 8'hA5;
    localparam logic [7:0] CMD_ENABLE       = 8'h01;
    localparam logic [7:0] CMD_DISABLE      = 8'h02;
    localparam logic [7:0] CMD_SINGLE_TRANS = 8'h03;
    localparam logic [7:0] CMD_BURST_TRANS  = 8'h04;
    localparam logic [7:0] POLY             = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CMD,
        ST_CNT,
        ST_WAIT_SMP,
        ST_PAYLOAD,
        ST_CRC
    } framer_state_t;

    // One full byte of CRC8, MSB first, so the framer updates in a single cycle.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic is_known_cmd(input logic [7:0] cmd);
        return (cmd == CMD_ENABLE) || (cmd == CMD_DISABLE) ||
               (cmd == CMD_SINGLE_TRANS) || (cmd == CMD_BURST_TRANS);
    endfunction

endpackage

// File: rtl/msg_sample_fifo.sv
// Small synchronous sample FIFO with show-ahead read data and a flush.
// A push while full is only taken when a pop frees a slot in the same cycle.
module msg_sample_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign o_full  = (count_reg == CW'(DEPTH));
    assign o_empty = (count_reg == '0);
    assign pop_ok  = i_pop & ~o_empty;
    assign push_ok = i_push & (~o_full | pop_ok);
    assign o_data  = mem[rd_ptr_reg];

    // Storage write; a flush discards the incoming sample as well.
    always_ff @(posedge i_clk) begin
        if (push_ok && !i_flush) begin
            mem[wr_ptr_reg] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-2 depth).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (i_flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_tx_msg_framer.sv
// Response framer: header, command, optional burst count, N-channel sample
// payload (ch0 first, LSB byte first) and a trailing CRC8, streamed one byte
// per handshake towards uart_tx.
module uart_tx_msg_framer
    import pkg_msg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 48,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [7:0]               i_cmd,
    input  logic                     i_cmd_valid,
    input  logic [7:0]               i_burst_cnt,
    input  logic                     i_abort,
    input  logic [NUM_CH*DATA_W-1:0] i_sample,
    input  logic                     i_sample_valid,
    output logic [7:0]               o_tx_byte,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic                     o_overflow,
    output logic                     o_cmd_drop
);
    localparam int         SMP_W    = NUM_CH * DATA_W;
    localparam int         BPS      = SMP_W / 8;
    localparam logic [7:0] LAST_IDX = 8'(BPS - 1);

    framer_state_t    state_reg;
    framer_state_t    state_next;
    logic [7:0]       cmd_reg;
    logic [7:0]       remain_reg;
    logic [7:0]       byte_idx_reg;
    logic [7:0]       crc_reg;
    logic [SMP_W-1:0] shift_reg;
    logic             overflow_reg;

    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic [SMP_W-1:0] fifo_data;
    logic             tx_valid;
    logic [7:0]       tx_byte;
    logic             xfer;
    logic             cmd_accept;
    logic             last_byte;

    msg_sample_fifo #(
        .WIDTH (SMP_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_abort),
        .i_push  (i_sample_valid),
        .i_data  (i_sample),
        .i_pop   (fifo_pop),
        .o_data  (fifo_data),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign xfer       = tx_valid & i_tx_ready;
    assign cmd_accept = (state_reg == ST_IDLE) & i_cmd_valid & is_known_cmd(i_cmd) & ~i_abort;
    assign last_byte  = (byte_idx_reg == LAST_IDX);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_reg <= ST_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state selection; abort overrides everything.
    always_comb begin
        state_next = state_reg;
        if (i_abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:     if (cmd_accept) state_next = ST_HDR;
                ST_HDR:      if (xfer) state_next = ST_CMD;
                ST_CMD: begin
                    if (xfer) begin
                        if (cmd_reg == CMD_BURST_TRANS)       state_next = ST_CNT;
                        else if (cmd_reg == CMD_SINGLE_TRANS) state_next = ST_WAIT_SMP;
                        else                                  state_next = ST_CRC;
                    end
                end
                ST_CNT:      if (xfer) state_next = (remain_reg == 8'd0) ? ST_CRC : ST_WAIT_SMP;
                ST_WAIT_SMP: if (!fifo_empty) state_next = ST_PAYLOAD;
                ST_PAYLOAD:  if (xfer && last_byte) state_next = (remain_reg == 8'd1) ? ST_CRC : ST_WAIT_SMP;
                ST_CRC:      if (xfer) state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    // Byte presented to uart_tx and FIFO pop request, decoded from state.
    always_comb begin
        tx_valid = 1'b0;
        tx_byte  = 8'h00;
        fifo_pop = 1'b0;
        case (state_reg)
            ST_HDR:      begin tx_valid = 1'b1; tx_byte = BYTE_HEADER;     end
            ST_CMD:      begin tx_valid = 1'b1; tx_byte = cmd_reg;         end
            ST_CNT:      begin tx_valid = 1'b1; tx_byte = remain_reg;      end
            ST_PAYLOAD:  begin tx_valid = 1'b1; tx_byte = shift_reg[7:0];  end
            ST_CRC:      begin tx_valid = 1'b1; tx_byte = crc_reg;         end
            ST_WAIT_SMP: fifo_pop = ~fifo_empty & ~i_abort;
            default:     ;
        endcase
    end

    // Frame datapath: latched command/count, payload shifter, CRC and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_reg      <= '0;
            remain_reg   <= '0;
            byte_idx_reg <= '0;
            crc_reg      <= '0;
            shift_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (cmd_accept) begin
                cmd_reg    <= i_cmd;
                remain_reg <= (i_cmd == CMD_BURST_TRANS) ? i_burst_cnt : 8'd1;
            end else if (state_reg == ST_PAYLOAD && xfer && last_byte) begin
                remain_reg <= remain_reg - 8'd1;
            end

            if (fifo_pop) begin
                shift_reg    <= fifo_data;
                byte_idx_reg <= '0;
            end else if (state_reg == ST_PAYLOAD && xfer) begin
                shift_reg    <= shift_reg >> 8;
                byte_idx_reg <= byte_idx_reg + 8'd1;
            end

            // CRC restarts whenever the framer heads back to IDLE.
            if (i_abort || (state_reg == ST_CRC && xfer)) begin
                crc_reg <= '0;
            end else if (xfer) begin
                crc_reg <= crc8_byte(crc_reg, tx_byte);
            end

            // A dropped sample outranks a same-cycle clear so it is never lost.
            if (i_sample_valid && fifo_full && !fifo_pop && !i_abort) begin
                overflow_reg <= 1'b1;
            end else if (cmd_accept) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign o_tx_valid   = tx_valid;
    assign o_tx_byte    = tx_byte;
    assign o_busy       = (state_reg != ST_IDLE);
    assign o_frame_done = (state_reg == ST_CRC) & xfer & ~i_abort;
    assign o_overflow   = overflow_reg;
    assign o_cmd_drop   = i_cmd_valid & (state_reg != ST_IDLE) & ~i_abort;

endmodule

// File: tb/tb_uart_tx_msg_framer.sv
// Scoreboard bench for uart_tx_msg_framer: stimulus pushes whole expected
// frames into a queue, a negedge monitor pops one byte per handshake.
`timescale 1ns/1ps
module tb_uart_tx_msg_framer;
    import pkg_msg::*;

    localparam int NUM_CH     = 2;
    localparam int DATA_W     = 48;
    localparam int FIFO_DEPTH = 4;
    localparam int SMP_W      = NUM_CH * DATA_W;
    localparam int BPS        = SMP_W / 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic [7:0]       i_cmd = '0;
    logic             i_cmd_valid = 1'b0;
    logic [7:0]       i_burst_cnt = '0;
    logic             i_abort = 1'b0;
    logic [SMP_W-1:0] i_sample = '0;
    logic             i_sample_valid = 1'b0;
    logic [7:0]       o_tx_byte;
    logic             o_tx_valid;
    logic             i_tx_ready = 1'b0;
    logic             o_busy;
    logic             o_frame_done;
    logic             o_overflow;
    logic             o_cmd_drop;

    always #5 i_clk = ~i_clk;

    uart_tx_msg_framer #(
        .NUM_CH     (NUM_CH),
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_cmd          (i_cmd),
        .i_cmd_valid    (i_cmd_valid),
        .i_burst_cnt    (i_burst_cnt),
        .i_abort        (i_abort),
        .i_sample       (i_sample),
        .i_sample_valid (i_sample_valid),
        .o_tx_byte      (o_tx_byte),
        .o_tx_valid     (o_tx_valid),
        .i_tx_ready     (i_tx_ready),
        .o_busy         (o_busy),
        .o_frame_done   (o_frame_done),
        .o_overflow     (o_overflow),
        .o_cmd_drop     (o_cmd_drop)
    );

    typedef struct {
        logic [7:0] b;
        bit         last;
    } exp_t;

    exp_t             exp_q[$];
    logic [SMP_W-1:0] mq[$];      // reference view of the sample FIFO contents
    int               errors = 0;
    int               checks = 0;
    int               xfer_cnt = 0;
    int               ready_mode = 0;  // 0 always, 1 one-in-three, 2 random, 3 up to limit, 4 never
    int               ready_limit = 0;
    int               ready_ph = 0;

    // CRC8 as the remainder of the zero-augmented message divided by x^8+POLY.
    function automatic logic [7:0] ref_crc(input logic [7:0] msg[$]);
        logic [7:0] rem;
        logic [7:0] cur;
        bit         top;
        bit         b;
        int         nbits;
        rem   = 8'h00;
        nbits = msg.size() * 8 + 8;
        for (int i = 0; i < nbits; i++) begin
            if (i < msg.size() * 8) begin
                cur = msg[i / 8];
                b   = cur[7 - (i % 8)];
            end else begin
                b = 1'b0;
            end
            top = rem[7];
            rem = {rem[6:0], b};
            if (top) rem = rem ^ POLY;
        end
        return rem;
    endfunction

    function automatic bit model_push(input logic [SMP_W-1:0] s);
        if (mq.size() < FIFO_DEPTH) begin
            mq.push_back(s);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Queue the bytes of one frame; trunc >= 0 keeps only that many leading bytes (aborted frame).
    task automatic expect_frame(input logic [7:0] cmd, input logic [7:0] cnt, input int nsmp, input int trunc);
        logic [7:0]       msg[$];
        logic [SMP_W-1:0] s;
        int               n;
        msg.push_back(BYTE_HEADER);
        msg.push_back(cmd);
        if (cmd == CMD_BURST_TRANS) msg.push_back(cnt);
        for (int k = 0; k < nsmp; k++) begin
            s = mq.pop_front();
            for (int j = 0; j < BPS; j++) msg.push_back(s[8*j +: 8]);
        end
        n = (trunc >= 0) ? trunc : msg.size();
        for (int k = 0; k < n; k++) exp_q.push_back('{b: msg[k], last: 1'b0});
        if (trunc < 0) exp_q.push_back('{b: ref_crc(msg), last: 1'b1});
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic drive_cmd(input logic [7:0] c, input logic [7:0] cnt);
        i_cmd = c;
        i_burst_cnt = cnt;
        i_cmd_valid = 1'b1;
        tick();
        i_cmd_valid = 1'b0;
    endtask

    task automatic drive_sample(input logic [SMP_W-1:0] s);
        i_sample = s;
        i_sample_valid = 1'b1;
        tick();
        i_sample_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || o_busy) && n < 2000) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s timeout: %0d bytes outstanding busy=%0b required 0 and 0", name, exp_q.size(), o_busy);
            exp_q.delete();
        end
    endtask

    function automatic logic [SMP_W-1:0] rand_sample();
        logic [SMP_W-1:0] s;
        for (int k = 0; k < SMP_W / 32; k++) s[32*k +: 32] = $urandom();
        return s;
    endfunction

    // Sink backpressure generator.
    always @(posedge i_clk) begin
        #1;
        case (ready_mode)
            0: i_tx_ready = 1'b1;
            1: begin ready_ph = (ready_ph + 1) % 3; i_tx_ready = (ready_ph == 0); end
            2: i_tx_ready = ($urandom_range(0, 1) == 1);
            3: i_tx_ready = (xfer_cnt < ready_limit);
            default: i_tx_ready = 1'b0;
        endcase
    end

    // Monitor: one compare per handshake, plus hold checks while stalled.
    logic [7:0] held_byte;
    bit         stalled = 1'b0;
    exp_t       e;
    always @(negedge i_clk) begin
        if (!i_rst_n || i_abort) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!(o_tx_valid === 1'b1 && o_tx_byte === held_byte)) begin
                    errors++;
                    $display("FAIL hold: valid=%0b byte=%02h required valid=1 byte=%02h", o_tx_valid, o_tx_byte, held_byte);
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                xfer_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected byte: got %02h required none", o_tx_byte);
                end else begin
                    e = exp_q.pop_front();
                    if (o_tx_byte !== e.b) begin
                        errors++;
                        $display("FAIL tx_byte: got %02h required %02h", o_tx_byte, e.b);
                    end
                    checks++;
                    if (o_frame_done !== e.last) begin
                        errors++;
                        $display("FAIL frame_done: got %0b required %0b", o_frame_done, e.last);
                    end
                    $display("tx byte=%02h expected=%02h done=%0b", o_tx_byte, e.b, o_frame_done);
                end
                stalled = 1'b0;
            end else if (o_tx_valid) begin
                stalled = 1'b1;
                held_byte = o_tx_byte;
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [SMP_W-1:0] s;
        logic [SMP_W-1:0] smp[5];
        logic [7:0]       cmds[4];
        logic [7:0]       c;
        logic [7:0]       cnt;
        int               n;
        int               base;
        bit               dropped;

        cmds[0] = CMD_ENABLE;
        cmds[1] = CMD_DISABLE;
        cmds[2] = CMD_SINGLE_TRANS;
        cmds[3] = CMD_BURST_TRANS;

        // Reset state
        tick(); tick();
        check("rst tx_valid", 64'(o_tx_valid), 64'd0);
        check("rst tx_byte", 64'(o_tx_byte), 64'd0);
        check("rst busy", 64'(o_busy), 64'd0);
        check("rst overflow", 64'(o_overflow), 64'd0);
        check("rst frame_done", 64'(o_frame_done), 64'd0);
        check("rst cmd_drop", 64'(o_cmd_drop), 64'd0);
        i_rst_n = 1'b1;
        tick();

        // 1: ENABLE streams on three consecutive cycles
        ready_mode = 0;
        tick();
        expect_frame(CMD_ENABLE, 8'd0, 0, -1);
        drive_cmd(CMD_ENABLE, 8'd0);
        check("t1 valid hdr", 64'(o_tx_valid), 64'd1);
        check("t1 hdr", 64'(o_tx_byte), 64'(BYTE_HEADER));
        tick();
        check("t1 valid cmd", 64'(o_tx_valid), 64'd1);
        check("t1 cmd", 64'(o_tx_byte), 64'(CMD_ENABLE));
        tick();
        check("t1 valid crc", 64'(o_tx_valid), 64'd1);
        check("t1 done with crc", 64'(o_frame_done), 64'd1);
        wait_done("t1");

        // 2: SINGLE with fixed sample -> 15 bytes
        base = xfer_cnt;
        s = {48'h0C0B_0A09_0807, 48'h0605_0403_0201};
        dropped = !model_push(s);
        expect_frame(CMD_SINGLE_TRANS, 8'd0, 1, -1);
        drive_cmd(CMD_SINGLE_TRANS, 8'd0);
        drive_sample(s);
        wait_done("t2");
        check("t2 byte count", 64'(xfer_cnt - base), 64'd15);

        // 3: BURST 3 under 1-in-3 backpressure, 5 samples pushed -> one dropped
        ready_mode = 1;
        base = xfer_cnt;
        dropped = 1'b0;
        for (int k = 0; k < 5; k++) begin
            smp[k] = rand_sample();
            if (!model_push(smp[k])) dropped = 1'b1;
        end
        expect_frame(CMD_BURST_TRANS, 8'd3, 3, -1);
        drive_cmd(CMD_BURST_TRANS, 8'd3);
        for (int k = 0; k < 5; k++) drive_sample(smp[k]);
        check("t3 overflow", 64'(o_overflow), 64'(dropped));
        wait_done("t3");
        check("t3 byte count", 64'(xfer_cnt - base), 64'd40);
        check("t3 overflow sticky", 64'(o_overflow), 64'd1);

        // 4: BURST 0 -> no payload, leftover sample stays queued, overflow cleared
        ready_mode = 2;
        expect_frame(CMD_BURST_TRANS, 8'd0, 0, -1);
        drive_cmd(CMD_BURST_TRANS, 8'd0);
        check("t4 overflow cleared", 64'(o_overflow), 64'd0);
        wait_done("t4");

        // 5: abort while stalled on payload byte 7 (consumes the leftover sample)
        ready_mode = 3;
        ready_limit = xfer_cnt + 9;
        expect_frame(CMD_SINGLE_TRANS, 8'd0, 1, 9);
        drive_cmd(CMD_SINGLE_TRANS, 8'd0);
        n = 0;
        while (xfer_cnt < ready_limit && n < 200) begin tick(); n++; end
        check("t5 reached byte 7", 64'(xfer_cnt >= ready_limit), 64'd1);
        drive_sample(rand_sample());
        tick();
        check("t5 stalled valid", 64'(o_tx_valid), 64'd1);
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        mq.delete();
        check("t5 valid after abort", 64'(o_tx_valid), 64'd0);
        check("t5 busy after abort", 64'(o_busy), 64'd0);
        check("t5 leftover bytes", 64'(exp_q.size()), 64'd0);
        ready_mode = 0;
        expect_frame(CMD_ENABLE, 8'd0, 0, -1);
        drive_cmd(CMD_ENABLE, 8'd0);
        wait_done("t5 enable");
        s = rand_sample();
        dropped = !model_push(s);
        expect_frame(CMD_SINGLE_TRANS, 8'd0, 1, -1);
        drive_cmd(CMD_SINGLE_TRANS, 8'd0);
        drive_sample(s);
        wait_done("t5 flushed single");

        // 6: command during HDR is dropped, frame unaffected
        expect_frame(CMD_DISABLE, 8'd0, 0, -1);
        drive_cmd(CMD_DISABLE, 8'd0);
        i_cmd = CMD_ENABLE;
        i_cmd_valid = 1'b1;
        #1;
        check("t6 cmd_drop", 64'(o_cmd_drop), 64'd1);
        tick();
        i_cmd_valid = 1'b0;
        #1;
        check("t6 cmd_drop low", 64'(o_cmd_drop), 64'd0);
        wait_done("t6");

        // Unknown command is ignored
        drive_cmd(8'h55, 8'd0);
        check("unknown cmd busy", 64'(o_busy), 64'd0);
        check("unknown cmd valid", 64'(o_tx_valid), 64'd0);

        // Reset mid-frame
        ready_mode = 4;
        drive_cmd(CMD_BURST_TRANS, 8'd2);
        tick();
        i_rst_n = 1'b0;
        #1;
        check("mid rst valid", 64'(o_tx_valid), 64'd0);
        check("mid rst byte", 64'(o_tx_byte), 64'd0);
        check("mid rst busy", 64'(o_busy), 64'd0);
        check("mid rst done", 64'(o_frame_done), 64'd0);
        check("mid rst overflow", 64'(o_overflow), 64'd0);
        tick();
        i_rst_n = 1'b1;
        mq.delete();
        tick();
        ready_mode = 0;
        expect_frame(CMD_ENABLE, 8'd0, 0, -1);
        drive_cmd(CMD_ENABLE, 8'd0);
        wait_done("post rst enable");

        // Random frames with random backpressure and sample timing
        ready_mode = 2;
        for (int it = 0; it < 12; it++) begin
            c   = cmds[$urandom_range(0, 3)];
            cnt = 8'($urandom_range(0, 3));
            n   = (c == CMD_SINGLE_TRANS) ? 1 : (c == CMD_BURST_TRANS) ? int'(cnt) : 0;
            for (int k = 0; k < n; k++) begin
                smp[k] = rand_sample();
                dropped = !model_push(smp[k]);
            end
            expect_frame(c, cnt, n, -1);
            drive_cmd(c, cnt);
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 4)) tick();
                drive_sample(smp[k]);
            end
            wait_done("random");
            check("random overflow", 64'(o_overflow), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
